// File: rtl/wb_pkg.sv
// Shared types and defaults for the writeback queue.
package wb_pkg;
  localparam int REG_COUNT          = 8;
  localparam int DEFAULT_DEPTH      = 4;
  localparam int DEFAULT_DATA_WIDTH = 16;
  localparam int DEFAULT_REG_BITS   = 3;

  typedef struct packed {
    logic [DEFAULT_REG_BITS-1:0]   reg_num;
    logic [DEFAULT_DATA_WIDTH-1:0] data;
  } wb_entry_t;

  function automatic logic [REG_COUNT-1:0] reg_onehot(input logic [DEFAULT_REG_BITS-1:0] r);
    return REG_COUNT'(1) << r;
  endfunction
endpackage

// File: rtl/writeback_queue_if.sv
// Producer handshakes, register-file write port and status of the writeback queue.
// Handshake: a result transfers on a rising clk where valid && ready; while valid && !ready
// the producer holds reg/data stable. The register-file side has no back-pressure.
interface writeback_queue_if #(
  parameter int DEPTH      = 4,
  parameter int DATA_WIDTH = 16,
  parameter int REG_BITS   = 3
);
  logic                      mem_valid;
  logic [REG_BITS-1:0]       mem_reg;
  logic [DATA_WIDTH-1:0]     mem_data;
  logic                      mem_ready;
  logic                      alu_valid;
  logic [REG_BITS-1:0]       alu_reg;
  logic [DATA_WIDTH-1:0]     alu_data;
  logic                      alu_ready;
  logic                      write;
  logic [REG_BITS-1:0]       write_reg_num;
  logic [DATA_WIDTH-1:0]     write_data;
  logic [(2**REG_BITS)-1:0]  pending;
  logic [$clog2(DEPTH):0]    count;

  modport slave (
    input  mem_valid, mem_reg, mem_data, alu_valid, alu_reg, alu_data,
    output mem_ready, alu_ready, write, write_reg_num, write_data, pending, count
  );
  modport master (
    output mem_valid, mem_reg, mem_data, alu_valid, alu_reg, alu_data,
    input  mem_ready, alu_ready, write, write_reg_num, write_data, pending, count
  );
endinterface

// File: rtl/wb_fifo.sv
// Dual-enqueue, single-dequeue circular buffer with occupancy vector and per-slot key tap.
module wb_fifo #(
  parameter int DEPTH   = 4,
  parameter int ENTRY_W = 19,
  parameter int KEY_W   = 3
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enq_a_i,
  input  logic [ENTRY_W-1:0]          data_a_i,
  input  logic                        enq_b_i,
  input  logic [ENTRY_W-1:0]          data_b_i,
  input  logic                        deq_i,
  output logic [ENTRY_W-1:0]          head_o,
  output logic [$clog2(DEPTH):0]      count_o,
  output logic [DEPTH-1:0]            occ_o,
  output logic [DEPTH-1:0][KEY_W-1:0] keys_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]   head_q, tail_q;
  logic [CNT_W-1:0]   count_q;
  logic [PTR_W-1:0]   offset;

  // enq_b only ever accompanies enq_a, so it always lands in the slot after enq_a.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      tail_q  <= tail_q + PTR_W'(enq_a_i) + PTR_W'(enq_b_i);
      head_q  <= head_q + PTR_W'(deq_i);
      count_q <= count_q + CNT_W'(enq_a_i) + CNT_W'(enq_b_i) - CNT_W'(deq_i);
    end
  end

  always_ff @(posedge clk) begin
    if (enq_a_i) mem_q[tail_q] <= data_a_i;
    if (enq_b_i) mem_q[tail_q + PTR_W'(1)] <= data_b_i;
  end

  always_comb begin
    occ_o  = '0;
    offset = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset   = PTR_W'(i) - head_q;
      occ_o[i] = ({1'b0, offset} < count_q);
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_keys
    assign keys_o[g] = mem_q[g][ENTRY_W-1 -: KEY_W];
  end

  assign head_o  = mem_q[head_q];
  assign count_o = count_q;
endmodule

// File: rtl/writeback_queue.sv
// Writeback queue: ALU/load intake, in-order drain to the register file, pending bitmap.
// Define WB_BYPASS_EN for zero-latency pass-through of the oldest result when the queue is empty.
module writeback_queue
  import wb_pkg::*;
#(
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int REG_BITS   = DEFAULT_REG_BITS
) (
  input  logic             clk,
  input  logic             reset,
  writeback_queue_if.slave wb
);
  localparam int CNT_W   = $clog2(DEPTH) + 1;
  localparam int ENTRY_W = REG_BITS + DATA_WIDTH;

  logic [CNT_W-1:0]              count;
  logic [CNT_W:0]                free;
  logic [ENTRY_W-1:0]            head, mem_entry, alu_entry, enq_a_data, out_entry;
  logic                          mem_fire, alu_fire, enq_a, enq_b, deq;
  logic [DEPTH-1:0]              occ;
  logic [DEPTH-1:0][REG_BITS-1:0] keys;

  // Room is judged on the registered count only; this cycle's drain does not free a slot.
  assign free         = (CNT_W+1)'(DEPTH) - {1'b0, count};
  assign wb.mem_ready = (free != '0);
  assign wb.alu_ready = (free >= ((CNT_W+1)'(1) + (CNT_W+1)'(wb.mem_valid)));
  assign mem_fire     = wb.mem_valid && wb.mem_ready;
  assign alu_fire     = wb.alu_valid && wb.alu_ready;
  assign mem_entry    = {wb.mem_reg, wb.mem_data};
  assign alu_entry    = {wb.alu_reg, wb.alu_data};
  assign deq          = (count != '0);

`ifdef WB_BYPASS_EN
  logic               empty, bypass;
  logic [ENTRY_W-1:0] first_entry;
  assign empty       = (count == '0);
  assign first_entry = mem_fire ? mem_entry : alu_entry;
  assign bypass      = empty && (mem_fire || alu_fire);
  // On an empty queue the oldest result goes straight out; only a second one is stored.
  assign enq_a       = empty ? (mem_fire && alu_fire) : (mem_fire || alu_fire);
  assign enq_a_data  = empty ? alu_entry : first_entry;
  assign enq_b       = !empty && mem_fire && alu_fire;
  assign out_entry   = empty ? first_entry : head;
  assign wb.write    = !empty || bypass;
`else
  assign enq_a       = mem_fire || alu_fire;
  assign enq_a_data  = mem_fire ? mem_entry : alu_entry;
  assign enq_b       = mem_fire && alu_fire;
  assign out_entry   = head;
  assign wb.write    = (count != '0);
`endif

  wb_fifo #(
    .DEPTH   (DEPTH),
    .ENTRY_W (ENTRY_W),
    .KEY_W   (REG_BITS)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .enq_a_i  (enq_a),
    .data_a_i (enq_a_data),
    .enq_b_i  (enq_b),
    .data_b_i (alu_entry),
    .deq_i    (deq),
    .head_o   (head),
    .count_o  (count),
    .occ_o    (occ),
    .keys_o   (keys)
  );

  always_comb begin
    wb.pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (occ[i]) wb.pending[keys[i]] = 1'b1;
    end
  end

  assign wb.write_reg_num = out_entry[ENTRY_W-1 -: REG_BITS];
  assign wb.write_data    = out_entry[DATA_WIDTH-1:0];
  assign wb.count         = count;
endmodule

// File: tb/tb_writeback_queue.sv
// Directed bench for writeback_queue with a queue model and register-file scoreboard.
module tb_writeback_queue;
  import wb_pkg::*;

  localparam int DEPTH = 4;
  localparam int DW    = 16;
  localparam int RB    = 3;

  typedef struct packed {
    logic          mv;
    logic [RB-1:0] mr;
    logic [DW-1:0] md;
    logic          av;
    logic [RB-1:0] ar;
    logic [DW-1:0] ad;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  writeback_queue_if #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .REG_BITS(RB)) wbi ();

  writeback_queue #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .REG_BITS(RB)) dut (
    .clk   (clk),
    .reset (reset),
    .wb    (wbi.slave)
  );

  int checks = 0;
  int errors = 0;
  int obs_writes = 0;
  wb_entry_t exp_q[$];
  logic [DW-1:0] exp_rf [REG_COUNT];
  logic [DW-1:0] obs_rf [REG_COUNT];

  vec_t mix [10] = '{
    '{1'b1, 3'd0, 16'h0A00, 1'b1, 3'd1, 16'h0B01},
    '{1'b0, 3'd0, 16'h0000, 1'b1, 3'd4, 16'h0C04},
    '{1'b1, 3'd6, 16'h0D06, 1'b0, 3'd0, 16'h0000},
    '{1'b1, 3'd7, 16'h0E07, 1'b1, 3'd7, 16'h0F07},
    '{1'b1, 3'd1, 16'h1001, 1'b1, 3'd0, 16'h1100},
    '{1'b1, 3'd4, 16'h1204, 1'b1, 3'd6, 16'h1306},
    '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000},
    '{1'b0, 3'd0, 16'h0000, 1'b1, 3'd3, 16'h1403},
    '{1'b1, 3'd3, 16'h1503, 1'b1, 3'd5, 16'h1605},
    '{1'b1, 3'd5, 16'h1705, 1'b1, 3'd1, 16'h1801}
  };

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock of stimulus; outputs are sampled mid-low-phase and compared with the model.
  task automatic drive(input logic mv, input logic [RB-1:0] mr, input logic [DW-1:0] md,
                       input logic av, input logic [RB-1:0] ar, input logic [DW-1:0] ad);
    int cnt;
    logic exp_mr, exp_ar, mf, af, has_w, byp;
    logic [REG_COUNT-1:0] exp_pend;
    wb_entry_t me, ae, we;
    @(negedge clk);
    wbi.mem_valid = mv; wbi.mem_reg = mr; wbi.mem_data = md;
    wbi.alu_valid = av; wbi.alu_reg = ar; wbi.alu_data = ad;
    #1;
    cnt    = exp_q.size();
    exp_mr = (cnt < DEPTH);
    exp_ar = ((DEPTH - cnt) >= (1 + int'(mv)));
    exp_pend = '0;
    foreach (exp_q[i]) exp_pend |= reg_onehot(exp_q[i].reg_num);
    check("mem_ready", wbi.mem_ready, exp_mr);
    check("alu_ready", wbi.alu_ready, exp_ar);
    check("count", wbi.count, cnt);
    check("pending", wbi.pending, exp_pend);
    mf = mv && exp_mr;
    af = av && exp_ar;
    me = '{reg_num: mr, data: md};
    ae = '{reg_num: ar, data: ad};
    has_w = 1'b0;
    we = '0;
    byp = 1'b0;
`ifdef WB_BYPASS_EN
    byp = (cnt == 0) && (mf || af);
`endif
    if (byp) begin
      has_w = 1'b1;
      we = mf ? me : ae;
      if (mf && af) exp_q.push_back(ae);
    end else begin
      if (cnt != 0) begin
        has_w = 1'b1;
        we = exp_q.pop_front();
      end
      if (mf) exp_q.push_back(me);
      if (af) exp_q.push_back(ae);
    end
    check("write", wbi.write, has_w);
    if (has_w) begin
      check("write_reg", wbi.write_reg_num, we.reg_num);
      check("write_data", wbi.write_data, we.data);
      exp_rf[we.reg_num] = we.data;
    end
    if (wbi.write) begin
      obs_rf[wbi.write_reg_num] = wbi.write_data;
      obs_writes++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  initial begin
    for (int r = 0; r < REG_COUNT; r++) begin
      exp_rf[r] = '0;
      obs_rf[r] = '0;
    end
    wbi.mem_valid = 1'b0; wbi.mem_reg = '0; wbi.mem_data = '0;
    wbi.alu_valid = 1'b0; wbi.alu_reg = '0; wbi.alu_data = '0;

    // Reset state
    @(negedge clk); #1;
    check("rst_write", wbi.write, 1'b0);
    check("rst_count", wbi.count, 0);
    check("rst_pending", wbi.pending, 0);
    check("rst_mem_ready", wbi.mem_ready, 1'b1);
    check("rst_alu_ready", wbi.alu_ready, 1'b1);
    @(negedge clk);
    reset = 1'b0;

    // Single ALU result into an empty queue
    drive(1'b0, '0, '0, 1'b1, 3'd3, 16'hBEEF);
`ifdef WB_BYPASS_EN
    check("t1_bypass_pending", wbi.pending, 0);
`else
    check("t1_no_early_write", wbi.write, 1'b0);
`endif
    idle(2);
    check("t1_rf3", obs_rf[3], 16'hBEEF);

    // Same-cycle mem and alu to one register: mem is older, alu wins
    drive(1'b1, 3'd2, 16'h1111, 1'b1, 3'd2, 16'h2222);
    idle(3);
    check("t2_rf2", obs_rf[2], 16'h2222);
    check("t2_pending_clear", wbi.pending, 0);

    // Back-to-back dual intake up to capacity, then alu-only stream
    for (int i = 0; i < 6; i++)
      drive(1'b1, RB'(i), DW'(16'h2000 + i), 1'b1, RB'(i + 2), DW'(16'h3000 + i));
    check("t3_cap_alu_ready", wbi.alu_ready, 1'b0);
    for (int i = 0; i < 6; i++)
      drive(1'b0, '0, '0, 1'b1, RB'(7 - i), DW'(16'h4000 + i));
    idle(5);
    check("t3_drained", wbi.count, 0);

    // Reset in the middle of a stream
    drive(1'b1, 3'd1, 16'h5001, 1'b1, 3'd2, 16'h5002);
    drive(1'b1, 3'd3, 16'h5003, 1'b0, '0, '0);
    @(negedge clk);
    wbi.mem_valid = 1'b0;
    wbi.alu_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("mid_rst_write", wbi.write, 1'b0);
    check("mid_rst_count", wbi.count, 0);
    check("mid_rst_pending", wbi.pending, 0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    obs_writes = 0;
    drive(1'b0, '0, '0, 1'b1, 3'd5, 16'h00FF);
    idle(3);
    check("post_rst_writes", obs_writes, 1);
    check("post_rst_rf5", obs_rf[5], 16'h00FF);

    // Mixed traffic table, then drain and compare register files
    foreach (mix[i]) drive(mix[i].mv, mix[i].mr, mix[i].md, mix[i].av, mix[i].ar, mix[i].ad);
    idle(6);
    check("final_count", wbi.count, 0);
    for (int r = 0; r < REG_COUNT; r++) check($sformatf("rf%0d", r), obs_rf[r], exp_rf[r]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
